// File: rtl/id_hazard_if.sv
// ID-stage hazard scoreboard bus: issue-side request signals in, ready/forward/status out.
interface id_hazard_if #(
    parameter int RW   = 5,
    parameter int NSRC = 3,
    parameter int LLW  = 6,
    parameter int CNTW = 32
) ();
    logic                flush;
    logic                pipe_adv;
    logic                id_valid;
    logic [NSRC-1:0]     id_src_en;
    logic [NSRC*RW-1:0]  id_src;
    logic                id_dst_en;
    logic [RW-1:0]       id_dst;
    logic [1:0]          id_avail;
    logic [LLW-1:0]      id_ll_cycles;
    logic                id_ready;
    logic [NSRC*2-1:0]   id_fwd_sel;
    logic                ll_busy;
    logic [CNTW-1:0]     stall_cnt;

    modport master (
        output flush, pipe_adv, id_valid, id_src_en, id_src, id_dst_en, id_dst, id_avail, id_ll_cycles,
        input  id_ready, id_fwd_sel, ll_busy, stall_cnt
    );

    modport slave (
        input  flush, pipe_adv, id_valid, id_src_en, id_src, id_dst_en, id_dst, id_avail, id_ll_cycles,
        output id_ready, id_fwd_sel, ll_busy, stall_cnt
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Tracks in-flight GPR writers (EXE..WB shift pipe plus one long-latency unit) and
// decides per ID source whether to issue, forward, or stall.
module id_hazard_scoreboard #(
    parameter int RW        = 5,
    parameter int NSRC      = 3,
    parameter int DEPTH     = 3,
    parameter int FLUSH_DEP = 1,
    parameter int LLW       = 6,
    parameter int CNTW      = 32
) (
    input  logic       clk,
    input  logic       resetn,
    id_hazard_if.slave bus
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dst;
        logic [1:0]    avail;
    } entry_t;

    entry_t            ent [1:DEPTH];
    entry_t            new_ent;
    logic [LLW-1:0]    ll_cnt;
    logic [LLW-1:0]    ll_load_val;
    logic [RW-1:0]     ll_dst;
    logic [CNTW-1:0]   stall_cnt_q;
    logic              ll_busy;
    logic              ll_op;
    logic              ready;
    logic              issue;
    logic [NSRC-1:0]   src_stall;
    logic [NSRC*2-1:0] fwd_sel;
    logic [RW-1:0]     src;
    logic              found;

    assign ll_busy = (ll_cnt != '0);
    assign ll_op   = bus.id_dst_en && (bus.id_avail == 2'd0);

    // Youngest match decides: forward if its result is ready at that stage, else stall.
    always_comb begin
        src_stall = '0;
        fwd_sel   = '0;
        src       = '0;
        found     = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src   = bus.id_src[i*RW +: RW];
            found = 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && bus.id_src_en[i] && (src != '0) && ent[k].valid && (ent[k].dst == src)) begin
                    found = 1'b1;
                    if (int'(ent[k].avail) <= k)
                        fwd_sel[i*2 +: 2] = (k > 3) ? 2'd3 : 2'(k);
                    else
                        src_stall[i] = 1'b1;
                end
            end
            if (ll_busy && bus.id_src_en[i] && (src != '0) && (src == ll_dst))
                src_stall[i] = 1'b1;
        end
    end

    always_comb begin
        ready = !(|src_stall)
              && !(ll_busy && ll_op)
              && !(ll_busy && bus.id_dst_en && (bus.id_dst == ll_dst))
              && !bus.flush;
        issue       = bus.id_valid && ready && bus.pipe_adv;
        new_ent     = '0;
        if (issue && bus.id_dst_en && (bus.id_avail != 2'd0))
            new_ent = {1'b1, bus.id_dst, bus.id_avail};
        ll_load_val = (bus.id_ll_cycles == '0) ? LLW'(1) : bus.id_ll_cycles;
    end

    // A flush kills the writers that were in stages 1..FLUSH_DEP, even if they shift this edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 1; k <= DEPTH; k++)
                ent[k] <= '0;
        end else begin
            if (bus.pipe_adv)
                ent[1] <= new_ent;
            else if (bus.flush)
                ent[1] <= '0;
            for (int k = 2; k <= DEPTH; k++) begin
                if (bus.pipe_adv) begin
                    if (bus.flush && (k - 1 <= FLUSH_DEP))
                        ent[k] <= '0;
                    else
                        ent[k] <= ent[k-1];
                end else if (bus.flush && (k <= FLUSH_DEP)) begin
                    ent[k] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ll_cnt      <= '0;
            ll_dst      <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue && ll_op) begin
                ll_cnt <= ll_load_val;
                ll_dst <= bus.id_dst;
            end else if (bus.flush) begin
                ll_cnt <= '0;
            end else if (ll_busy) begin
                ll_cnt <= ll_cnt - 1'b1;
            end
            if (bus.id_valid && !ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.id_ready   = ready;
    assign bus.id_fwd_sel = fwd_sel;
    assign bus.ll_busy    = ll_busy;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed hazard scenarios plus random traffic, all checked
// every cycle against a list-of-writers reference model.
module tb_id_hazard_scoreboard;
    localparam int RW = 5, NSRC = 3, DEPTH = 3, FLUSH_DEP = 1, LLW = 6, CNTW = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    id_hazard_if #(.RW(RW), .NSRC(NSRC), .LLW(LLW), .CNTW(CNTW)) bus ();

    id_hazard_scoreboard #(
        .RW(RW), .NSRC(NSRC), .DEPTH(DEPTH), .FLUSH_DEP(FLUSH_DEP), .LLW(LLW), .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    // Reference model: each in-flight writer carries the stage it currently occupies.
    typedef struct {
        int dst;
        int avail;
        int stage;
    } wr_t;

    wr_t    flight[$];
    int     ll_left = 0;
    int     ll_dst  = 0;
    longint stalls  = 0;

    int     errs   = 0;
    int     checks = 0;

    int     npin = 0;
    int     pin_code [4];
    int     pin_idx  [4];
    int     pin_val  [4];
    string  pin_name [4];

    function automatic int src_of(int i);
        return int'(bus.id_src[i*RW +: RW]);
    endfunction

    function automatic void predict(output bit rdy, output logic [2*NSRC-1:0] sel);
        rdy = !bus.flush;
        sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            int s    = src_of(i);
            int best = 0;
            int bav  = 0;
            if (!bus.id_src_en[i] || s == 0) continue;
            foreach (flight[j])
                if (flight[j].dst == s && (best == 0 || flight[j].stage < best)) begin
                    best = flight[j].stage;
                    bav  = flight[j].avail;
                end
            if (best != 0) begin
                if (bav <= best) sel[i*2 +: 2] = (best > 3) ? 2'd3 : 2'(best);
                else rdy = 1'b0;
            end
            if (ll_left > 0 && s == ll_dst) rdy = 1'b0;
        end
        if (ll_left > 0 && bus.id_dst_en) begin
            if (bus.id_avail == 2'd0) rdy = 1'b0;
            if (int'(bus.id_dst) == ll_dst) rdy = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flight.delete();
            ll_left = 0;
            ll_dst  = 0;
            stalls  = 0;
        end else begin
            bit               r;
            bit               iss;
            logic [2*NSRC-1:0] s;
            wr_t              w;
            predict(r, s);
            iss = bus.id_valid && r && bus.pipe_adv;
            if (bus.id_valid && !r && stalls < 64'hFFFF_FFFF) stalls++;
            if (bus.flush)
                for (int j = flight.size() - 1; j >= 0; j--)
                    if (flight[j].stage <= FLUSH_DEP) flight.delete(j);
            if (bus.pipe_adv) begin
                foreach (flight[j]) flight[j].stage++;
                for (int j = flight.size() - 1; j >= 0; j--)
                    if (flight[j].stage > DEPTH) flight.delete(j);
                if (iss && bus.id_dst_en && bus.id_avail != 2'd0) begin
                    w.dst   = int'(bus.id_dst);
                    w.avail = int'(bus.id_avail);
                    w.stage = 1;
                    flight.push_back(w);
                end
            end
            if (iss && bus.id_dst_en && bus.id_avail == 2'd0) begin
                ll_left = (bus.id_ll_cycles == 0) ? 1 : int'(bus.id_ll_cycles);
                ll_dst  = int'(bus.id_dst);
            end else if (bus.flush) begin
                ll_left = 0;
            end else if (ll_left > 0) begin
                ll_left--;
            end
        end
    end

    // Single compare process: model vs DUT every cycle, plus literal pins on chosen cycles.
    always @(negedge clk) begin
        bit               r;
        logic [2*NSRC-1:0] s;
        int               dv;
        int               mv;
        predict(r, s);
        checks++;
        if (bus.id_ready !== r) begin
            errs++;
            $display("FAIL id_ready t=%0t got=%b exp=%b", $time, bus.id_ready, r);
        end
        checks++;
        if (bus.id_fwd_sel !== s) begin
            errs++;
            $display("FAIL id_fwd_sel t=%0t got=%h exp=%h", $time, bus.id_fwd_sel, s);
        end
        checks++;
        if (bus.ll_busy !== (ll_left > 0)) begin
            errs++;
            $display("FAIL ll_busy t=%0t got=%b exp=%b", $time, bus.ll_busy, (ll_left > 0));
        end
        checks++;
        if (bus.stall_cnt !== CNTW'(stalls)) begin
            errs++;
            $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, bus.stall_cnt, stalls);
        end
        for (int p = 0; p < npin; p++) begin
            case (pin_code[p])
                1:       begin dv = int'(bus.id_ready);                   mv = int'(r); end
                2:       begin dv = int'(bus.id_fwd_sel[pin_idx[p]*2 +: 2]); mv = int'(s[pin_idx[p]*2 +: 2]); end
                3:       begin dv = int'(bus.ll_busy);                    mv = (ll_left > 0) ? 1 : 0; end
                default: begin dv = int'(bus.stall_cnt);                  mv = int'(stalls); end
            endcase
            checks++;
            if (dv != pin_val[p]) begin
                errs++;
                $display("FAIL %s t=%0t got=%0d exp=%0d", pin_name[p], $time, dv, pin_val[p]);
            end
            checks++;
            if (mv != pin_val[p]) begin
                errs++;
                $display("FAIL model_%s t=%0t model=%0d exp=%0d", pin_name[p], $time, mv, pin_val[p]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        npin = 0;
    endtask

    task automatic pin(int code, int idx, int val, string name);
        pin_code[npin] = code;
        pin_idx[npin]  = idx;
        pin_val[npin]  = val;
        pin_name[npin] = name;
        npin++;
    endtask

    task automatic drive(bit v, logic [NSRC-1:0] en, int s0, int s1, int s2,
                         bit de, int d, int av, int cyc, bit adv, bit fl);
        bus.id_valid     = v;
        bus.id_src_en    = en;
        bus.id_src       = {RW'(s2), RW'(s1), RW'(s0)};
        bus.id_dst_en    = de;
        bus.id_dst       = RW'(d);
        bus.id_avail     = 2'(av);
        bus.id_ll_cycles = LLW'(cyc);
        bus.pipe_adv     = adv;
        bus.flush        = fl;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
    endtask

    initial begin
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        next_cycle();
        pin(1, 0, 1, "rst_ready"); pin(2, 0, 0, "rst_sel0");
        pin(3, 0, 0, "rst_ll_busy"); pin(4, 0, 0, "rst_stall_cnt");
        next_cycle();
        resetn = 1'b1;

        // ALU result forwarded from EXE
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 3, 1, 0, 1, 0); pin(1, 0, 1, "t1_issue_ready");
        next_cycle(); drive(1, 3'b001, 3, 0, 0, 0, 0, 0, 0, 1, 0);
        pin(1, 0, 1, "t1_ready"); pin(2, 0, 1, "t1_sel0");
        idle(3);

        // load-use: one stall then forward from MEM
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 4, 2, 0, 1, 0);
        next_cycle(); drive(1, 3'b010, 0, 4, 0, 0, 0, 0, 0, 1, 0); pin(1, 0, 0, "t2_stall");
        next_cycle(); drive(1, 3'b010, 0, 4, 0, 0, 0, 0, 0, 1, 0);
        pin(1, 0, 1, "t2_ready"); pin(2, 1, 2, "t2_sel1"); pin(4, 0, 1, "t2_stall_cnt");
        idle(3);

        // youngest producer wins; r0 never matches
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 0, 3, 0, 1, 0);
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 6, 1, 0, 1, 0);
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 6, 1, 0, 1, 0);
        next_cycle(); drive(1, 3'b011, 6, 0, 0, 0, 0, 0, 0, 1, 0);
        pin(2, 0, 1, "t3_sel0"); pin(2, 1, 0, "t3_sel1_r0"); pin(1, 0, 1, "t3_ready");
        idle(3);

        // long-latency RAW then structural stall
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 5, 0, 4, 1, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); drive(1, 3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0);
            pin(1, 0, 0, "t4_raw_stall"); pin(3, 0, 1, "t4_busy");
        end
        next_cycle(); drive(1, 3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        pin(1, 0, 1, "t4_raw_ready"); pin(3, 0, 0, "t4_idle"); pin(4, 0, 5, "t4_stall_cnt");
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 10, 0, 4, 1, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 11, 0, 1, 1, 0);
            pin(1, 0, 0, "t4_struct_stall");
        end
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 11, 0, 1, 1, 0);
        pin(1, 0, 1, "t4_struct_ready"); pin(4, 0, 9, "t4_stall_cnt2");
        idle(3);

        // pipeline hold keeps the MEM-available producer in EXE
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 7, 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); drive(1, 3'b001, 7, 0, 0, 0, 0, 0, 0, 0, 0);
            pin(1, 0, 0, "t5_hold_stall");
        end
        next_cycle(); drive(1, 3'b001, 7, 0, 0, 0, 0, 0, 0, 1, 0); pin(1, 0, 0, "t5_adv_stall");
        next_cycle(); drive(1, 3'b001, 7, 0, 0, 0, 0, 0, 0, 1, 0);
        pin(1, 0, 1, "t5_ready"); pin(2, 0, 2, "t5_sel0");
        idle(3);

        // flush aborts LL op and kills the EXE writer
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 12, 0, 10, 1, 0);
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 8, 3, 0, 1, 0); pin(1, 0, 1, "t6_r8_issue");
        next_cycle(); drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        pin(1, 0, 0, "t6_flush_ready"); pin(3, 0, 1, "t6_busy_pre");
        next_cycle(); drive(1, 3'b011, 8, 12, 0, 0, 0, 0, 0, 1, 0);
        pin(3, 0, 0, "t6_busy_post"); pin(1, 0, 1, "t6_ready"); pin(2, 0, 0, "t6_sel0");

        // asynchronous reset in the middle of an LL op
        next_cycle(); drive(1, 3'b000, 0, 0, 0, 1, 13, 0, 20, 1, 0);
        next_cycle(); drive(1, 3'b001, 13, 0, 0, 0, 0, 0, 0, 1, 0); pin(1, 0, 0, "t6_ll_stall");
        next_cycle(); drive(1, 3'b001, 13, 0, 0, 0, 0, 0, 0, 1, 0);
        #2 resetn = 1'b0;
        pin(3, 0, 0, "t6_rst_busy"); pin(4, 0, 0, "t6_rst_stall_cnt"); pin(1, 0, 1, "t6_rst_ready");
        next_cycle(); resetn = 1'b1;
        idle(2);

        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (c == 1500) resetn = 1'b0;
            if (c == 1502) resetn = 1'b1;
            drive(($urandom_range(0, 9) < 8), NSRC'($urandom),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 6)), ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0));
        end

        idle(3);
        next_cycle();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
